sync_fifo_n: RTL and testbench

Parametrised synchronous FIFO, the multi-word successor to the single-entry holding register used on the codebase's streaming datapaths. It buffers up to 2**AW words of DW bits in first-word-fall-through (FWFT) order, so the head word is always visible on ReadData. It keeps the single-entry block's Ety/Full/Ovf/Unf semantics and adds an occupancy count, an almost-full threshold and optional sticky error capture. It sits between producer and consumer stages that need more than one word of elasticity.

---
 rtl/sync_fifo_n.sv | 99 +++++++++
 tb/tb_sync_fifo_n.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_n.sv
// sync_fifo_n: first-word-fall-through synchronous FIFO, 2**AW words of DW bits.
// Define SYNC_FIFO_N_STICKY_ERR_EN to add ErrClr/OvfSticky/UnfSticky.
module sync_fifo_n #(
    parameter int DW           = 32,
    parameter int AW           = 2,
    parameter int AFULL_THRESH = 2**AW - 1
) (
    input  logic          Clk,
    input  logic          ARst,
    input  logic [DW-1:0] WriteData,
    input  logic          Wr,
    input  logic          Rd,
    output logic [DW-1:0] ReadData,
    output logic          Ety,
    output logic          Full,
    output logic          AFull,
    output logic [AW:0]   Count,
    output logic          Ovf,
    output logic          Unf
`ifdef SYNC_FIFO_N_STICKY_ERR_EN
    ,
    input  logic          ErrClr,
    output logic          OvfSticky,
    output logic          UnfSticky
`endif
);
    localparam int          DEPTH    = 2**AW;
    localparam logic [AW:0] LP_DEPTH = DEPTH[AW:0];
    localparam logic [AW:0] LP_AFULL = AFULL_THRESH[AW:0];

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign Ety      = (r_count == '0);
    assign Full     = (r_count == LP_DEPTH);
    assign AFull    = (r_count >= LP_AFULL);
    assign Count    = r_count;
    assign ReadData = r_mem[r_rp];

    // A pop frees the head slot this edge, so a full FIFO may still accept a push.
    assign w_push = Wr & (~Full | Rd);
    assign w_pop  = Rd & ~Ety;
    assign Ovf    = Full & Wr & ~Rd;
    assign Unf    = Ety & Rd;

    // Storage is deliberately not reset.
    always_ff @(posedge Clk) begin
        if (w_push && !ARst)
            r_mem[r_wp] <= WriteData;
    end

    always_ff @(posedge Clk) begin
        if (ARst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef SYNC_FIFO_N_STICKY_ERR_EN
    logic r_ovf_sticky;
    logic r_unf_sticky;

    // A new error event outranks a coincident clear.
    always_ff @(posedge Clk) begin
        if (ARst) begin
            r_ovf_sticky <= 1'b0;
            r_unf_sticky <= 1'b0;
        end else begin
            if (Ovf)
                r_ovf_sticky <= 1'b1;
            else if (ErrClr)
                r_ovf_sticky <= 1'b0;
            if (Unf)
                r_unf_sticky <= 1'b1;
            else if (ErrClr)
                r_unf_sticky <= 1'b0;
        end
    end

    assign OvfSticky = r_ovf_sticky;
    assign UnfSticky = r_unf_sticky;
`endif

endmodule

// File: tb/tb_sync_fifo_n.sv
// Self-checking bench for sync_fifo_n against a queue-based reference model.
module tb_sync_fifo_n;
    localparam int DW    = 32;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int THR   = 3;

    logic          Clk = 1'b0;
    logic          ARst;
    logic          Wr;
    logic          Rd;
    logic [DW-1:0] WriteData;
    logic [DW-1:0] ReadData;
    logic          Ety;
    logic          Full;
    logic          AFull;
    logic [AW:0]   Count;
    logic          Ovf;
    logic          Unf;
`ifdef SYNC_FIFO_N_STICKY_ERR_EN
    logic          ErrClr;
    logic          OvfSticky;
    logic          UnfSticky;
`endif

    int unsigned   n_tests = 0;
    int unsigned   n_fail  = 0;
    logic [DW-1:0] q[$];
    bit            m_ovfs = 1'b0;
    bit            m_unfs = 1'b0;

    always #5 Clk = ~Clk;

    sync_fifo_n #(
        .DW(DW),
        .AW(AW),
        .AFULL_THRESH(THR)
    ) dut (
        .Clk(Clk),
        .ARst(ARst),
        .WriteData(WriteData),
        .Wr(Wr),
        .Rd(Rd),
        .ReadData(ReadData),
        .Ety(Ety),
        .Full(Full),
        .AFull(AFull),
        .Count(Count),
        .Ovf(Ovf),
        .Unf(Unf)
`ifdef SYNC_FIFO_N_STICKY_ERR_EN
        ,
        .ErrClr(ErrClr),
        .OvfSticky(OvfSticky),
        .UnfSticky(UnfSticky)
`endif
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus, entered and left just after a falling edge.
    task automatic step(input logic wr, input logic rd, input logic rst, input logic clr,
                        input logic [DW-1:0] d);
        bit e_ovf;
        bit e_unf;
        bit do_push;
        bit do_pop;
        Wr        = wr;
        Rd        = rd;
        ARst      = rst;
        WriteData = d;
`ifdef SYNC_FIFO_N_STICKY_ERR_EN
        ErrClr    = clr;
`endif
        #1;
        e_ovf = (q.size() == DEPTH) && wr && !rd;
        e_unf = (q.size() == 0) && rd;
        chk("ovf", {31'b0, Ovf}, {31'b0, e_ovf});
        chk("unf", {31'b0, Unf}, {31'b0, e_unf});
        do_pop  = rd && (q.size() > 0);
        do_push = wr && ((q.size() < DEPTH) || rd);
        @(posedge Clk);
        if (rst) begin
            q.delete();
            m_ovfs = 1'b0;
            m_unfs = 1'b0;
        end else begin
            if (do_pop)
                void'(q.pop_front());
            if (do_push)
                q.push_back(d);
            if (e_ovf) m_ovfs = 1'b1;
            else if (clr) m_ovfs = 1'b0;
            if (e_unf) m_unfs = 1'b1;
            else if (clr) m_unfs = 1'b0;
        end
        #1;
        chk("count", {29'b0, Count}, q.size());
        chk("ety",   {31'b0, Ety},   {31'b0, q.size() == 0});
        chk("full",  {31'b0, Full},  {31'b0, q.size() == DEPTH});
        chk("afull", {31'b0, AFull}, {31'b0, q.size() >= THR});
        if (q.size() > 0)
            chk("head", ReadData, q[0]);
`ifdef SYNC_FIFO_N_STICKY_ERR_EN
        chk("ovf_sticky", {31'b0, OvfSticky}, {31'b0, m_ovfs});
        chk("unf_sticky", {31'b0, UnfSticky}, {31'b0, m_unfs});
`endif
        @(negedge Clk);
    endtask

    initial begin
        bit w;
        bit r;
        ARst      = 1'b1;
        Wr        = 1'b0;
        Rd        = 1'b1;
        WriteData = '0;
`ifdef SYNC_FIFO_N_STICKY_ERR_EN
        ErrClr    = 1'b0;
`endif
        @(posedge Clk);
        @(posedge Clk);
        #1;
        chk("rst_count", {29'b0, Count}, 32'd0);
        chk("rst_ety",   {31'b0, Ety},   32'd1);
        chk("rst_full",  {31'b0, Full},  32'd0);
        chk("rst_afull", {31'b0, AFull}, 32'd0);
        chk("rst_ovf",   {31'b0, Ovf},   32'd0);
        chk("rst_unf",   {31'b0, Unf},   32'd1);
`ifdef SYNC_FIFO_N_STICKY_ERR_EN
        chk("rst_ovfs",  {31'b0, OvfSticky}, 32'd0);
        chk("rst_unfs",  {31'b0, UnfSticky}, 32'd0);
`endif
        @(negedge Clk);
        ARst = 1'b0;
        Rd   = 1'b0;

        // Fill to full
        step(1, 0, 0, 0, 32'h11);
        step(1, 0, 0, 0, 32'h22);
        step(1, 0, 0, 0, 32'h33);
        chk("afull_at3", {31'b0, AFull}, 32'd1);
        step(1, 0, 0, 0, 32'h44);
        chk("fill_head", ReadData, 32'h11);
        chk("fill_full", {31'b0, Full}, 32'd1);

        // Overflow dropped, then drain in order
        step(1, 0, 0, 0, 32'h55);
        chk("ovf_head", ReadData, 32'h11);
        chk("ovf_count", {29'b0, Count}, 32'd4);
        for (int unsigned i = 0; i < 4; i++)
            step(0, 1, 0, 0, 32'h0);
        chk("drain_ety", {31'b0, Ety}, 32'd1);

        // Simultaneous push/pop while full
        step(1, 0, 0, 0, 32'h11);
        step(1, 0, 0, 0, 32'h22);
        step(1, 0, 0, 0, 32'h33);
        step(1, 0, 0, 0, 32'h44);
        for (int unsigned i = 0; i < 4; i++)
            step(1, 1, 0, 0, 32'h66);
        chk("wrrd_head", ReadData, 32'h66);
        chk("wrrd_count", {29'b0, Count}, 32'd4);
        for (int unsigned i = 0; i < 4; i++)
            step(0, 1, 0, 0, 32'h0);

        // Empty with Rd: underflow; with Wr too the push proceeds
        step(1, 1, 0, 0, 32'h77);
        chk("unf_push_head", ReadData, 32'h77);
        chk("unf_push_count", {29'b0, Count}, 32'd1);
        step(0, 1, 0, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0);
        chk("unf_alone_count", {29'b0, Count}, 32'd0);

        // Sticky flags: clear, overflow, hold, clear-vs-set, clear
        step(0, 0, 0, 1, 32'h0);
        for (int unsigned i = 0; i < 4; i++)
            step(1, 0, 0, 0, 32'h100 + i);
        step(1, 0, 0, 0, 32'hdead);
        step(0, 0, 0, 0, 32'h0);
`ifdef SYNC_FIFO_N_STICKY_ERR_EN
        chk("ovfs_hold", {31'b0, OvfSticky}, 32'd1);
`endif
        step(1, 0, 0, 1, 32'hbeef);
`ifdef SYNC_FIFO_N_STICKY_ERR_EN
        chk("ovfs_set_wins", {31'b0, OvfSticky}, 32'd1);
`endif
        step(0, 0, 0, 1, 32'h0);
        for (int unsigned i = 0; i < 4; i++)
            step(0, 1, 0, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
`ifdef SYNC_FIFO_N_STICKY_ERR_EN
        chk("unfs_hold", {31'b0, UnfSticky}, 32'd1);
`endif
        step(0, 0, 0, 1, 32'h0);

        // Randomized interleaved traffic with a mid-stream reset
        for (int unsigned i = 0; i < 80; i++) begin
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 45);
            if (i == 40) begin
                step(w, r, 1, 0, $urandom);
                chk("midrst_count", {29'b0, Count}, 32'd0);
                chk("midrst_ety", {31'b0, Ety}, 32'd1);
            end else begin
                step(w, r, 0, $urandom_range(0, 7) == 0, $urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish within 200000 time units");
        $fatal(1, "timeout");
    end
endmodule
